// File: rtl/l2_responder_pkg.sv
// l2_responder_pkg: shared widths and payload types for the L2 line responder.
// Provides the 128-bit line type, the line-offset width and the latched
// request payload used by l2_responder.
package l2_responder_pkg;

  localparam int unsigned L2_ADDR_W      = 16;
  localparam int unsigned L2_OFFSET_W    = 4;
  localparam int unsigned L2_LINE_W      = 128;
  localparam int unsigned L2_LINE_ADDR_W = L2_ADDR_W - L2_OFFSET_W;
  localparam int unsigned L2_CNT_W       = 16;

  localparam logic [L2_CNT_W-1:0] L2_CNT_MAX = '1;

  typedef logic [L2_LINE_W-1:0] lc3b_l2_line;

  // Upstream request as captured in S_IDLE; the byte offset is not kept.
  typedef struct packed {
    logic                      write;
    logic [L2_LINE_ADDR_W-1:0] line;
    lc3b_l2_line               wdata;
  } l2_req_t;

endpackage

// File: rtl/l2_responder_array.sv
// l2_array: SETS-deep register array, synchronous write, combinational read.
// Ports: clk, reset (sync, active-high, clears contents only when HAS_RESET),
//        load (write enable), index, datain, dataout.
module l2_array #(
  parameter int unsigned SETS      = 8,
  parameter int unsigned WIDTH     = 1,
  parameter bit          HAS_RESET = 1'b0,
  localparam int unsigned IDX_W    = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [IDX_W-1:0] index,
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] dataout
);

  logic [WIDTH-1:0] mem [SETS];

  // Storage update; only state arrays (valid/dirty) are cleared by reset.
  always_ff @(posedge clk) begin
    if (HAS_RESET && reset) begin
      for (int i = 0; i < SETS; i++) begin
        mem[i] <= '0;
      end
    end else if (load) begin
      mem[index] <= datain;
    end
  end

  assign dataout = mem[index];

endmodule

// File: rtl/l2_responder.sv
// l2_responder: direct-mapped, write-back, write-allocate store of 128-bit
// lines behind the arbitrated L1 port; physical memory is used only on a miss.
// Ports: clk; reset (sync, active-high); l2_mem_read/write/address/wdata in,
//        l2_mem_rdata/resp out (slave handshake); pmem_read/write/address/
//        wdata out, pmem_rdata/resp in (master handshake).
// Optional: define L2_PERF_CNT_EN to add saturating hit_count/miss_count.
module l2_responder
  import l2_responder_pkg::*;
#(
  parameter int unsigned SETS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 l2_mem_read,
  input  logic                 l2_mem_write,
  input  logic [L2_ADDR_W-1:0] l2_mem_address,
  input  logic [L2_LINE_W-1:0] l2_mem_wdata,
  output logic [L2_LINE_W-1:0] l2_mem_rdata,
  output logic                 l2_mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [L2_ADDR_W-1:0] pmem_address,
  output logic [L2_LINE_W-1:0] pmem_wdata,
  input  logic [L2_LINE_W-1:0] pmem_rdata,
  input  logic                 pmem_resp
`ifdef L2_PERF_CNT_EN
  ,
  output logic [L2_CNT_W-1:0]  hit_count,
  output logic [L2_CNT_W-1:0]  miss_count
`endif
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = L2_LINE_ADDR_W - IDX_W;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LOOKUP    = 2'd1;
  localparam logic [1:0] S_WRITEBACK = 2'd2;
  localparam logic [1:0] S_FILL      = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_next;
  l2_req_t          req;
  logic             accept;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit;

  lc3b_l2_line      data_out;
  lc3b_l2_line      data_in;
  logic [TAG_W-1:0] tag_out;
  logic             valid_out;
  logic             dirty_out;
  logic             dirty_in;
  logic             data_load;
  logic             tag_load;
  logic             valid_load;
  logic             dirty_load;

  // Byte-offset bits carry no meaning for whole-line requests.
  logic addr_offset_unused;
  assign addr_offset_unused = ^l2_mem_address[L2_OFFSET_W-1:0];

  assign idx     = req.line[IDX_W-1:0];
  assign req_tag = req.line[L2_LINE_ADDR_W-1:IDX_W];
  assign hit     = valid_out && (tag_out == req_tag);

  // Array writes are blocked during reset so an abandoned fill never lands.
  l2_array #(.SETS(SETS), .WIDTH(L2_LINE_W), .HAS_RESET(1'b0)) u_data (
    .clk(clk), .reset(reset), .load(data_load && !reset),
    .index(idx), .datain(data_in), .dataout(data_out)
  );

  l2_array #(.SETS(SETS), .WIDTH(TAG_W), .HAS_RESET(1'b0)) u_tag (
    .clk(clk), .reset(reset), .load(tag_load && !reset),
    .index(idx), .datain(req_tag), .dataout(tag_out)
  );

  l2_array #(.SETS(SETS), .WIDTH(1), .HAS_RESET(1'b1)) u_valid (
    .clk(clk), .reset(reset), .load(valid_load && !reset),
    .index(idx), .datain(1'b1), .dataout(valid_out)
  );

  l2_array #(.SETS(SETS), .WIDTH(1), .HAS_RESET(1'b1)) u_dirty (
    .clk(clk), .reset(reset), .load(dirty_load && !reset),
    .index(idx), .datain(dirty_in), .dataout(dirty_out)
  );

  // State and request capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      req   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        req <= '{write: l2_mem_write,
                 line:  l2_mem_address[L2_ADDR_W-1:L2_OFFSET_W],
                 wdata: l2_mem_wdata};
      end
    end
  end

  // Next state, array updates and handshake outputs.
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    l2_mem_resp  = 1'b0;
    l2_mem_rdata = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    data_in      = pmem_rdata;
    data_load    = 1'b0;
    tag_load     = 1'b0;
    valid_load   = 1'b0;
    dirty_load   = 1'b0;
    dirty_in     = 1'b0;

    case (state)
      S_IDLE: begin
        if (l2_mem_read || l2_mem_write) begin
          accept     = 1'b1;
          state_next = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (hit) begin
          l2_mem_resp = 1'b1;
          state_next  = S_IDLE;
          if (req.write) begin
            data_in    = req.wdata;
            data_load  = 1'b1;
            dirty_in   = 1'b1;
            dirty_load = 1'b1;
          end else begin
            l2_mem_rdata = data_out;
          end
        end else if (valid_out && dirty_out) begin
          state_next = S_WRITEBACK;
        end else begin
          state_next = S_FILL;
        end
      end

      S_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_out, idx, L2_OFFSET_W'(0)};
        pmem_wdata   = data_out;
        if (pmem_resp) begin
          dirty_load = 1'b1;
          state_next = S_FILL;
        end
      end

      S_FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, idx, L2_OFFSET_W'(0)};
        if (pmem_resp) begin
          data_load  = 1'b1;
          tag_load   = 1'b1;
          valid_load = 1'b1;
          dirty_load = 1'b1;
          state_next = S_LOOKUP;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

`ifdef L2_PERF_CNT_EN
  // retry marks the lookup that follows a fill so it is not counted again.
  logic retry;

  always_ff @(posedge clk) begin
    if (reset) begin
      retry      <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state == S_FILL && pmem_resp) begin
        retry <= 1'b1;
      end else if (state == S_IDLE) begin
        retry <= 1'b0;
      end
      if (state == S_LOOKUP && !retry) begin
        if (hit) begin
          if (hit_count != L2_CNT_MAX) hit_count <= hit_count + L2_CNT_W'(1);
        end else begin
          if (miss_count != L2_CNT_MAX) miss_count <= miss_count + L2_CNT_W'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_l2_responder.sv
// tb_l2_responder: scoreboard bench for l2_responder with a physical memory
// model that answers pmem requests after a programmable number of waits.
module tb_l2_responder;
  import l2_responder_pkg::*;

  typedef logic [127:0] line_t;
  typedef struct { bit rd; line_t data; } sb_t;
  typedef struct { bit wr; logic [15:0] addr; line_t data; } pm_t;

  logic        clk;
  logic        reset;
  logic        l2_mem_read;
  logic        l2_mem_write;
  logic [15:0] l2_mem_address;
  line_t       l2_mem_wdata;
  line_t       l2_mem_rdata;
  logic        l2_mem_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  line_t       pmem_wdata;
  line_t       pmem_rdata;
  logic        pmem_resp;
`ifdef L2_PERF_CNT_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  int    checks = 0;
  int    failures = 0;
  bit    mon_en = 1'b0;
  bit    pm_en = 1'b1;
  int    pmem_waits = 0;
  logic  pm_resp_auto;
  line_t pm_rdata_auto;
  logic  pm_resp_man;
  line_t pm_rdata_man;

  sb_t   sb_q[$];
  pm_t   pm_log[$];
  line_t pmem_mem[logic [15:0]];
  line_t gold[logic [15:0]];

  assign pmem_resp  = pm_en ? pm_resp_auto  : pm_resp_man;
  assign pmem_rdata = pm_en ? pm_rdata_auto : pm_rdata_man;

  l2_responder #(.SETS(8)) dut (
    .clk(clk),
    .reset(reset),
    .l2_mem_read(l2_mem_read),
    .l2_mem_write(l2_mem_write),
    .l2_mem_address(l2_mem_address),
    .l2_mem_wdata(l2_mem_wdata),
    .l2_mem_rdata(l2_mem_rdata),
    .l2_mem_resp(l2_mem_resp),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp)
`ifdef L2_PERF_CNT_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input line_t obs, input line_t exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic line_t pmem_val(input logic [15:0] a);
    if (pmem_mem.exists(a)) return pmem_mem[a];
    return {8{a}};
  endfunction

  // Coherent memory view: latest written line, else what pmem holds.
  function automatic line_t gold_val(input logic [15:0] a);
    logic [15:0] l;
    l = a & 16'hFFF0;
    if (gold.exists(l)) return gold[l];
    return pmem_val(l);
  endfunction

  // Issue one request at a negedge, wait for resp, return latency in cycles.
  task automatic do_req(input bit wr, input logic [15:0] addr, input line_t wdata,
                        output int lat);
    sb_t e;
    e.rd   = !wr;
    e.data = wr ? '0 : gold_val(addr);
    if (wr) gold[addr & 16'hFFF0] = wdata;
    sb_q.push_back(e);
    l2_mem_read    = !wr;
    l2_mem_write   = wr;
    l2_mem_address = addr;
    l2_mem_wdata   = wdata;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!l2_mem_resp && lat < 200);
    check_val("resp_seen", 128'(l2_mem_resp), 128'(1));
    l2_mem_read  = 1'b0;
    l2_mem_write = 1'b0;
    @(negedge clk);
    check_val("resp_pulse", 128'(l2_mem_resp), 128'(0));
  endtask

  task automatic check_pm(input string tag, input int i, input bit wr,
                          input logic [15:0] addr);
    if (pm_log.size() > i) begin
      check_val({tag, "_op"}, 128'(pm_log[i].wr), 128'(wr));
      check_val({tag, "_addr"}, 128'(pm_log[i].addr), 128'(addr));
    end else begin
      check_val({tag, "_present"}, 128'(pm_log.size()), 128'(i + 1));
    end
  endtask

  // Physical memory model.
  initial begin
    int          wait_cnt;
    logic [15:0] held_addr;
    wait_cnt      = 0;
    held_addr     = '0;
    pm_resp_auto  = 1'b0;
    pm_rdata_auto = '0;
    forever begin
      @(negedge clk);
      pm_resp_auto  = 1'b0;
      pm_rdata_auto = '0;
      if (pm_en && !reset && (pmem_read || pmem_write)) begin
        if (wait_cnt == 0) held_addr = pmem_address;
        if (wait_cnt >= pmem_waits) begin
          if (wait_cnt > 0) check_val("pmem_hold", 128'(pmem_address), 128'(held_addr));
          if (pmem_write) begin
            pmem_mem[pmem_address] = pmem_wdata;
            pm_log.push_back('{wr: 1'b1, addr: pmem_address, data: pmem_wdata});
          end else begin
            pm_rdata_auto = pmem_val(pmem_address);
            pm_log.push_back('{wr: 1'b0, addr: pmem_address, data: pm_rdata_auto});
          end
          pm_resp_auto = 1'b1;
          wait_cnt     = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Response monitor and per-cycle invariants.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (l2_mem_resp) begin
          if (sb_q.size() == 0) begin
            check_val("unexp_resp", 128'(l2_mem_resp), 128'(0));
          end else begin
            e = sb_q.pop_front();
            if (e.rd) check_val("rdata", l2_mem_rdata, e.data);
          end
        end else begin
          check_val("rdata_idle", l2_mem_rdata, '0);
        end
        check_val("pmem_excl", 128'(pmem_read & pmem_write), 128'(0));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int n;
    line_t wd;
    reset          = 1'b1;
    l2_mem_read    = 1'b0;
    l2_mem_write   = 1'b0;
    l2_mem_address = '0;
    l2_mem_wdata   = '0;
    pm_resp_man    = 1'b0;
    pm_rdata_man   = '0;
    pmem_mem[16'h1230] = {8{16'hAAAA}};
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check_val("rst_resp", 128'(l2_mem_resp), 128'(0));
    check_val("rst_rdata", l2_mem_rdata, '0);
    check_val("rst_pread", 128'(pmem_read), 128'(0));
    check_val("rst_pwrite", 128'(pmem_write), 128'(0));
    check_val("rst_paddr", 128'(pmem_address), 128'(0));
    check_val("rst_pwdata", pmem_wdata, '0);
`ifdef L2_PERF_CNT_EN
    check_val("rst_hits", 128'(hit_count), 128'(0));
    check_val("rst_misses", 128'(miss_count), 128'(0));
`endif
    mon_en = 1'b1;

    // Clean read miss with three wait states.
    pmem_waits = 3;
    pm_log.delete();
    do_req(1'b0, 16'h1234, '0, lat);
    check_val("miss_lat", 128'(lat), 128'(6));
    check_val("miss_pm_n", 128'(pm_log.size()), 128'(1));
    check_pm("miss_fill", 0, 1'b0, 16'h1230);

    // Read hit on the same line, different offset.
    pm_log.delete();
    do_req(1'b0, 16'h123E, '0, lat);
    check_val("hit_lat", 128'(lat), 128'(1));
    check_val("hit_pm_n", 128'(pm_log.size()), 128'(0));

    // Write hit, then conflicting read forces writeback before fill.
    do_req(1'b1, 16'h1230, {8{16'h5555}}, lat);
    check_val("whit_lat", 128'(lat), 128'(1));
    check_val("whit_pm_n", 128'(pm_log.size()), 128'(0));
    do_req(1'b0, 16'h12B0, '0, lat);
    check_val("dirty_lat", 128'(lat), 128'(10));
    check_val("dirty_pm_n", 128'(pm_log.size()), 128'(2));
    check_pm("dirty_wb", 0, 1'b1, 16'h1230);
    if (pm_log.size() > 0) check_val("dirty_wb_data", pm_log[0].data, {8{16'h5555}});
    check_pm("dirty_fill", 1, 1'b0, 16'h12B0);

    // Write miss allocates, then the written data wins over the fill data.
    pm_log.delete();
    wd = {4{32'h0123_4567}};
    do_req(1'b1, 16'h4000, wd, lat);
    check_val("wmiss_lat", 128'(lat), 128'(6));
    check_val("wmiss_pm_n", 128'(pm_log.size()), 128'(1));
    check_pm("wmiss_fill", 0, 1'b0, 16'h4000);
    do_req(1'b0, 16'h4000, '0, lat);
    check_val("wmiss_reread_lat", 128'(lat), 128'(1));

    // Mixed random traffic over a few conflicting tags.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] a;
      line_t       d;
      int          lt;
      a = 16'h8000 | 16'($urandom_range(0, 511));
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      pmem_waits = $urandom_range(0, 4);
      do_req($urandom_range(0, 1) == 1, a, d, lt);
    end

    // Reset while a fill is outstanding, with a pmem_resp in the reset cycle.
    pm_en = 1'b0;
    sb_q.push_back('{rd: 1'b1, data: '0});
    l2_mem_read    = 1'b1;
    l2_mem_address = 16'h1234;
    n = 0;
    do begin
      @(negedge clk);
      pm_resp_man = 1'b0;
      n++;
      if (pmem_write) begin
        pmem_mem[pmem_address] = pmem_wdata;
        pm_resp_man = 1'b1;
      end
    end while (!pmem_read && n < 50);
    check_val("rst_fill_req", 128'(pmem_read), 128'(1));
    check_val("rst_fill_addr", 128'(pmem_address), 128'(16'h1230));
    reset        = 1'b1;
    pm_resp_man  = 1'b1;
    pm_rdata_man = {8{16'hDEAD}};
    l2_mem_read  = 1'b0;
    @(negedge clk);
    reset       = 1'b0;
    pm_resp_man = 1'b0;
    check_val("abort_pread", 128'(pmem_read), 128'(0));
    check_val("abort_pwrite", 128'(pmem_write), 128'(0));
    check_val("abort_paddr", 128'(pmem_address), 128'(0));
    check_val("abort_resp", 128'(l2_mem_resp), 128'(0));
    sb_q.delete();
    gold.delete();
    repeat (3) @(negedge clk);
    check_val("abort_quiet", 128'(pmem_read | pmem_write), 128'(0));
    pm_en = 1'b1;

    // Lines were invalidated, so the same address misses again.
    pmem_waits = 2;
    pm_log.delete();
    do_req(1'b0, 16'h1234, '0, lat);
    check_val("post_rst_lat", 128'(lat), 128'(5));
    check_val("post_rst_pm_n", 128'(pm_log.size()), 128'(1));
    check_pm("post_rst_fill", 0, 1'b0, 16'h1230);

`ifdef L2_PERF_CNT_EN
    check_val("perf_hits0", 128'(hit_count), 128'(0));
    check_val("perf_misses0", 128'(miss_count), 128'(1));
    do_req(1'b0, 16'h1234, '0, lat);
    do_req(1'b0, 16'h5000, '0, lat);
    do_req(1'b0, 16'h5000, '0, lat);
    check_val("perf_hits", 128'(hit_count), 128'(2));
    check_val("perf_misses", 128'(miss_count), 128'(2));
`endif

    repeat (2) @(negedge clk);
    check_val("sb_drained", 128'(sb_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_responder.md
# l2_responder

Downstream responder for the arbitrated L1 memory port. It services the single request stream that the I/D arbiter forwards on the `l2_mem_*` interface. It does this with a direct-mapped, write-back, write-allocate line store of 128-bit lines, and goes to physical memory on the `pmem_*` interface only on a miss. It is the slave end of the same read/write/resp handshake the arbiter drives.

## Interface
- `SETS`, 8: number of lines; power of two, ≥2. `IDX_W = log2(SETS)`.
- `clk` in 1: sole clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `l2_mem_read` in 1: line read request; never asserted together with `l2_mem_write`.
- `l2_mem_write` in 1: full-line write request.
- `l2_mem_address` in 16: byte address; bits [3:0] ignored.
- `l2_mem_wdata` in 128: write line.
- `l2_mem_rdata` out 128: read line; valid in the `l2_mem_resp` cycle.
- `l2_mem_resp` out 1: one-cycle completion pulse.
- `pmem_read` out 1: physical line read request.
- `pmem_write` out 1: physical line write request.
- `pmem_address` out 16: line-aligned address, with [3:0] = 0.
- `pmem_wdata` out 128: victim line.
- `pmem_rdata` in 128: fill line; valid with `pmem_resp`.
- `pmem_resp` in 1: physical completion pulse.

## Operation
- Address split: offset [3:0], index [4+IDX_W-1:4], tag [15:4+IDX_W].
- Per-set state: valid, dirty, tag, 128-bit data.
- States:
  - **S_IDLE**: on read or write, latch the address and wdata, then go to S_LOOKUP.
  - **S_LOOKUP**: hit = valid && tag match.
    - Read hit: drive `l2_mem_rdata` from the array, assert `l2_mem_resp`, go to S_IDLE.
    - Write hit: load the latched wdata, set dirty, assert `l2_mem_resp`, go to S_IDLE.
    - Miss with valid && dirty: go to S_WRITEBACK.
    - Any other miss: go to S_FILL.
  - **S_WRITEBACK**: `pmem_write`=1, `pmem_address`={victim tag, index, 4'h0}, `pmem_wdata`=victim line, all held until `pmem_resp`; then clear dirty and go to S_FILL.
  - **S_FILL**: `pmem_read`=1, `pmem_address`={req tag, index, 4'h0}, held until `pmem_resp`. In the `pmem_resp` cycle: data ← `pmem_rdata`, tag ← req tag, valid=1, dirty=0, then go to S_LOOKUP. The retried lookup always hits.
- A write miss allocates by fill, then overwrites the line on the retried hit; the fill data is discarded.
- `pmem_read` and `pmem_write` are never both high.
- No upstream request is accepted outside S_IDLE.
- Upstream must hold its request until `l2_mem_resp`, then deassert. A new request presented in the cycle after `l2_mem_resp` is accepted in S_IDLE with no gap.
- `l2_mem_rdata` is 0 when `l2_mem_resp`=0.
- Reset:
  - State goes to S_IDLE; all valid and dirty bits clear; all outputs 0.
  - Tag and data arrays are not reset.
  - Reset mid-transaction abandons it: pmem request low from the next cycle, no `l2_mem_resp` issued, and an in-flight `pmem_resp` is ignored.

## Timing
- Request seen in S_IDLE at cycle 0 → hit `l2_mem_resp` at cycle 1.
- Clean miss: resp 1 cycle after the `pmem_resp` of the fill.
- Dirty miss: writeback, then fill, then resp 1 cycle after the fill's `pmem_resp`.
- Physical wait states are unbounded; outputs stay stable throughout.
- Outputs are combinational from state and registered arrays; no combinational path from `l2_mem_*` to `pmem_*`.

## Configuration
- `L2_PERF_CNT_EN` defined adds outputs `hit_count` and `miss_count`, 16 bits each, reset to 0.
  - `hit_count` increments once on each first-lookup hit.
  - `miss_count` increments once on each first-lookup miss.
  - The retried lookup after a fill is not counted.
  - Both counters saturate at 0xFFFF.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

## Structure
- `lc3b_types` gains `lc3b_l2_line` (128-bit) and the line-offset width constant (4).
- The state enum stays local to the module.
- One sub-module, `l2_array`: a SETS-deep register array with synchronous `load`, `index`, `datain` and combinational `dataout`. It is instantiated for data, tag, valid and dirty.

## Test plan
- Reset, read 0x1234 → `pmem_read` with `pmem_address`=0x1230. Return `pmem_rdata`=0xAAAA…AA after 3 waits → `l2_mem_rdata`=0xAAAA…AA with a single-cycle `l2_mem_resp` one cycle after `pmem_resp`.
- Read 0x123E next → resp on cycle 1, no `pmem_*` activity.
- Write 0x1230 with 0x5555…55 → resp on cycle 1. Then read 0x12B0 (same index 3) → `pmem_write` to 0x1230 with 0x5555…55, then `pmem_read` from 0x12B0, then resp.
- Write miss to 0x4000 → fill from 0x4000, then `l2_mem_resp`. Reread 0x4000 → returns the written data, not the fill data.
- Assert `reset` during S_FILL → `pmem_read`=0 next cycle, no `l2_mem_resp`. Reread 0x1234 → misses again.
- With `L2_PERF_CNT_EN`: the sequence hit, miss, hit → `hit_count`=2, `miss_count`=1.
